// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory arbiter slice.
// Port indices double as the value held in the round-robin last-grant register.
package dmem_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = 4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Response bookkeeping captured on every grant, consumed the following cycle.
  typedef struct packed {
    logic rd_pending;
    logic wr_err;
    logic rd_err;
    logic port;
  } rsp_t;

  function automatic logic [STRB_WIDTH-1:0] byte_enables(
    input logic                  we,
    input logic [STRB_WIDTH-1:0] wstrb
  );
    return we ? wstrb : {STRB_WIDTH{1'b0}};
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's handshake bundle toward the data-memory arbiter.
// The master side is the requester, the slave side is the arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  import dmem_pkg::*;

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick with its last-grant register.
// A lone requester always wins; a tie goes to the port that did not win last.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic       last_grant_r;
  logic [1:0] gnt_s;

  // Combinational pick; nothing is granted while reset is held.
  always_comb begin
    gnt_s = 2'b00;
    if (reset) begin
      gnt_s = 2'b00;
    end else begin
      case (req)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = (last_grant_r == PORT_DBG) ? 2'b01 : 2'b10;
        default: gnt_s = 2'b00;
      endcase
    end
  end

  // Remember the winner so the next tie flips to the other port.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= PORT_DBG;
    end else if (gnt_s != 2'b00) begin
      last_grant_r <= gnt_s[1];
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store port (p0)
// and the debug/loader port (p1); read returns go back to the issuing port.
module dmem_arbiter #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 32,
  parameter int DMEM_SIZE_IN_BYTES = 1024
) (
  input  logic                                    clk,
  input  logic                                    reset,
  dmem_arbiter_if.slave                           p0,
  dmem_arbiter_if.slave                           p1,
  output logic                                    mem_en,
  output logic [3:0]                              mem_we,
  output logic [$clog2(DMEM_SIZE_IN_BYTES/4)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]                   mem_wdata,
  input  logic [DATA_WIDTH-1:0]                   mem_rdata
);
  import dmem_pkg::*;

  localparam int                    WORD_AW    = $clog2(DMEM_SIZE_IN_BYTES / 4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(DMEM_SIZE_IN_BYTES);

  logic [1:0]            req_s;
  logic [1:0]            gnt_s;
  logic                  granted_s;
  logic                  in_range_s;
  logic                  sel_port_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [STRB_WIDTH-1:0] sel_wstrb_s;
  rsp_t                  rsp_r;

  logic                  p0_rvalid_s;
  logic                  p1_rvalid_s;
  logic                  p0_err_s;
  logic                  p1_err_s;
  logic [DATA_WIDTH-1:0] ret_data_s;

  assign req_s = {p1.req, p0.req};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .req   (req_s),
    .gnt   (gnt_s)
  );

  assign p0.gnt     = gnt_s[0];
  assign p1.gnt     = gnt_s[1];
  assign granted_s  = gnt_s[0] | gnt_s[1];
  assign in_range_s = (sel_addr_s < ADDR_LIMIT);

  // Steer the winning port's request fields toward the memory.
  always_comb begin
    sel_port_s  = PORT_CPU;
    sel_we_s    = p0.we;
    sel_addr_s  = p0.addr;
    sel_wdata_s = p0.wdata;
    sel_wstrb_s = p0.wstrb;
    if (gnt_s[1]) begin
      sel_port_s  = PORT_DBG;
      sel_we_s    = p1.we;
      sel_addr_s  = p1.addr;
      sel_wdata_s = p1.wdata;
      sel_wstrb_s = p1.wstrb;
    end else begin
      sel_port_s  = PORT_CPU;
    end
  end

  // Memory strobes only for an in-range granted access; otherwise all zero.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = {WORD_AW{1'b0}};
    mem_wdata = {DATA_WIDTH{1'b0}};
    if (granted_s && in_range_s) begin
      mem_en    = 1'b1;
      mem_we    = byte_enables(sel_we_s, sel_wstrb_s);
      mem_addr  = sel_addr_s[WORD_AW+1:2];
      mem_wdata = sel_wdata_s;
    end else begin
      mem_en    = 1'b0;
    end
  end

  // Capture who gets the return and whether it is an error; routing must
  // follow this captured port, not whichever port is granted next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_r.rd_pending <= 1'b0;
      rsp_r.wr_err     <= 1'b0;
      rsp_r.rd_err     <= 1'b0;
      rsp_r.port       <= PORT_CPU;
    end else begin
      rsp_r.rd_pending <= granted_s & ~sel_we_s;
      rsp_r.wr_err     <= granted_s & sel_we_s & ~in_range_s;
      rsp_r.rd_err     <= granted_s & ~sel_we_s & ~in_range_s;
      rsp_r.port       <= sel_port_s;
    end
  end

  // Return path; gated by reset so a read pending at reset never surfaces.
  always_comb begin
    p0_rvalid_s = 1'b0;
    p1_rvalid_s = 1'b0;
    p0_err_s    = 1'b0;
    p1_err_s    = 1'b0;
    ret_data_s  = {DATA_WIDTH{1'b0}};
    if (!reset) begin
      if (rsp_r.rd_pending && !rsp_r.rd_err) begin
        ret_data_s = mem_rdata;
      end else begin
        ret_data_s = {DATA_WIDTH{1'b0}};
      end
      if (rsp_r.port == PORT_DBG) begin
        p1_rvalid_s = rsp_r.rd_pending;
        p1_err_s    = rsp_r.rd_err | rsp_r.wr_err;
      end else begin
        p0_rvalid_s = rsp_r.rd_pending;
        p0_err_s    = rsp_r.rd_err | rsp_r.wr_err;
      end
    end else begin
      ret_data_s = {DATA_WIDTH{1'b0}};
    end
  end

  assign p0.rvalid = p0_rvalid_s;
  assign p1.rvalid = p1_rvalid_s;
  assign p0.err    = p0_err_s;
  assign p1.err    = p1_err_s;
  assign p0.rdata  = p0_rvalid_s ? ret_data_s : {DATA_WIDTH{1'b0}};
  assign p1.rdata  = p1_rvalid_s ? ret_data_s : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a behavioural memory, a shadow
// memory as reference, and a one-entry-per-cycle response scoreboard.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(32)) p0_if ();
  dmem_arbiter_if #(.ADDR_WIDTH(32)) p1_if ();

  dmem_arbiter #(
    .DATA_WIDTH         (32),
    .ADDR_WIDTH         (32),
    .DMEM_SIZE_IN_BYTES (1024)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .p0        (p0_if),
    .p1        (p1_if),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic [3:0]  s0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic [3:0]  s1;
    logic [1:0]  g;      // expected {p1_gnt, p0_gnt}
  } vec_t;

  typedef struct {
    logic        active;
    logic        port;
    logic        is_read;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic [31:0] ram    [256];
  logic [31:0] shadow [256];
  exp_t        sb [$];
  int          passed = 0;
  int          total  = 0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 8) return 32'hAAAAAAAA;
    return 32'h5A5A0000 | 32'(i);
  endfunction

  // Behavioural single-port memory, synchronous read of the old contents.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  function automatic vec_t mk(
    input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
    input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1,
    input logic [1:0] g);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.s0 = s0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.s1 = s1;
    v.g  = g;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    p0_if.req = v.r0; p0_if.we = v.w0; p0_if.addr = v.a0; p0_if.wdata = v.d0; p0_if.wstrb = v.s0;
    p1_if.req = v.r1; p1_if.we = v.w1; p1_if.addr = v.a1; p1_if.wdata = v.d1; p1_if.wstrb = v.s1;
  endtask

  task automatic check_returns(input int id);
    exp_t        e;
    logic [33:0] exp0, exp1;
    e = '{active: 1'b0, port: 1'b0, is_read: 1'b0, data: 32'h0, err: 1'b0};
    if (sb.size() > 0) e = sb.pop_front();
    exp0 = (e.active && !e.port) ? {e.is_read, e.err, e.data} : 34'h0;
    exp1 = (e.active &&  e.port) ? {e.is_read, e.err, e.data} : 34'h0;
    check($sformatf("c%0d_p0_rsp", id), {30'h0, p0_if.rvalid, p0_if.err, p0_if.rdata}, {30'h0, exp0});
    check($sformatf("c%0d_p1_rsp", id), {30'h0, p1_if.rvalid, p1_if.err, p1_if.rdata}, {30'h0, exp1});
  endtask

  task automatic check_grant(input vec_t v, input int id);
    logic        port, we, in_range;
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [7:0]  idx;
    exp_t        e;
    check($sformatf("c%0d_gnt", id), {62'h0, p1_if.gnt, p0_if.gnt}, {62'h0, v.g});
    e = '{active: 1'b0, port: 1'b0, is_read: 1'b0, data: 32'h0, err: 1'b0};
    if (v.g == 2'b00) begin
      check($sformatf("c%0d_mem_en", id), {63'h0, mem_en}, 64'h0);
    end else begin
      port = v.g[1];
      we   = port ? v.w1 : v.w0;
      a    = port ? v.a1 : v.a0;
      d    = port ? v.d1 : v.d0;
      s    = port ? v.s1 : v.s0;
      in_range = (a < 32'd1024);
      idx  = a[9:2];
      check($sformatf("c%0d_mem_en", id), {63'h0, mem_en}, {63'h0, in_range});
      if (in_range)
        check($sformatf("c%0d_mem_bus", id), {20'h0, mem_we, mem_addr, mem_wdata},
              {20'h0, (we ? s : 4'h0), idx, d});
      e.port = port;
      if (!we) begin
        e.active  = 1'b1;
        e.is_read = 1'b1;
        e.data    = in_range ? shadow[idx] : 32'h0;
        e.err     = !in_range;
      end else begin
        e.active = !in_range;
        e.err    = !in_range;
        if (in_range)
          for (int b = 0; b < 4; b++)
            if (s[b]) shadow[idx][8*b +: 8] = d[8*b +: 8];
      end
    end
    sb.push_back(e);
  endtask

  task automatic cycle(input vec_t v, input int id);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(v);
    @(negedge clk);
    check_returns(id);
    check_grant(v, id);
  endtask

  vec_t tbl [19];
  vec_t idle_v, both_v;

  initial begin
    idle_v = mk(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00);
    both_v = mk(1'b1, 1'b0, 32'h04, 32'h0, 4'h0, 1'b1, 1'b0, 32'h08, 32'h0, 4'h0, 2'b01);
    for (int i = 0; i < 6; i++) begin
      tbl[i] = both_v;
      tbl[i].g = (i % 2 == 0) ? 2'b01 : 2'b10;
    end
    tbl[6]  = mk(1'b1, 1'b0, 32'h10,  32'h0,        4'h0, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 2'b01);
    tbl[7]  = idle_v;
    tbl[8]  = mk(1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b1, 32'h20,  32'h12345678, 4'h3, 2'b10);
    tbl[9]  = mk(1'b1, 1'b0, 32'h20,  32'h0,        4'h0, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 2'b01);
    tbl[10] = mk(1'b1, 1'b0, 32'h30,  32'h0,        4'h0, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 2'b01);
    tbl[11] = mk(1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 32'h34,  32'h0,        4'h0, 2'b10);
    tbl[12] = mk(1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 32'h400, 32'h0,        4'h0, 2'b10);
    tbl[13] = mk(1'b1, 1'b1, 32'h404, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 2'b01);
    tbl[14] = mk(1'b1, 1'b1, 32'h40,  32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 32'h40,  32'h0,        4'h0, 2'b10);
    tbl[15] = mk(1'b1, 1'b1, 32'h40,  32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 2'b01);
    tbl[16] = mk(1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 32'h40,  32'h0,        4'h0, 2'b10);
    tbl[17] = mk(1'b1, 1'b0, 32'h3FC, 32'h0,        4'hF, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 2'b01);
    tbl[18] = idle_v;

    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);

    // Reset with both ports requesting: no grants, no memory strobe, quiet returns.
    reset = 1'b1;
    drive(both_v);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", {62'h0, p1_if.gnt, p0_if.gnt}, 64'h0);
    check("rst_mem_en", {63'h0, mem_en}, 64'h0);
    check_returns(-1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(idle_v);

    for (int i = 0; i < 19; i++) cycle(tbl[i], i);

    // Reset lands the cycle after a read grant: the return must never appear.
    cycle(tbl[6], 100);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(both_v);
    @(negedge clk);
    check("rst_drop_p0", {31'h0, p0_if.rvalid, p0_if.err, p0_if.rdata}, 64'h0);
    check("rst_drop_p1", {31'h0, p1_if.rvalid, p1_if.err, p1_if.rdata}, 64'h0);
    check("rst_drop_gnt", {62'h0, p1_if.gnt, p0_if.gnt}, 64'h0);
    sb.delete();
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);

    cycle(both_v, 101);
    tbl[0].g = 2'b10;
    cycle(tbl[0], 102);
    cycle(idle_v, 103);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the processor load/store port (port 0) and a debug/loader port (port 1). It sits between processor and data memory inside the SoC, so a host can read or write data memory while the core runs or after it halts. Arbitration is round-robin, and every read return is routed back to the port that issued it.

## Interface
- DATA_WIDTH, 32, data bus width; must be 32.
- ADDR_WIDTH, 32, byte address width on both request ports.
- DMEM_SIZE_IN_BYTES, 1024, memory size; word index width is log2(DMEM_SIZE_IN_BYTES/4).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- p0_req, p1_req  in  1  request valid; held until granted.
- p0_we, p1_we  in  1  1 = write, 0 = read.
- p0_addr, p1_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- p0_wdata, p1_wdata  in  32  write data.
- p0_wstrb, p1_wstrb  in  4  byte enables for writes.
- p0_gnt, p1_gnt  out  1  request accepted this cycle (combinational).
- p0_rvalid, p1_rvalid  out  1  read data valid, registered.
- p0_rdata, p1_rdata  out  32  read data; 0 when rvalid is low.
- p0_err, p1_err  out  1  pulses with rvalid/gnt-completion for an out-of-range access.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  per-byte write enable (wstrb gated by we).
- mem_addr  out  log2(DMEM_SIZE_IN_BYTES/4)  word index.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  synchronous read data, valid the cycle after mem_en.

## Operation
- State: last_grant (1 bit), rd_pending (1 bit), rd_port (1 bit), rd_err (1 bit).
- Exactly one grant per cycle at most; gnt asserts only with the matching req.
- Only one requester active: it is granted.
- Both active: grant the port not equal to last_grant; last_grant updates to the granted port on every grant.
- Granted access drives mem_en=1, mem_addr=addr[log2(size)-1:2], mem_wdata, mem_we=wstrb when we else 4'b0.
- Out-of-range access (addr >= DMEM_SIZE_IN_BYTES): granted, mem_en=0, write discarded; reads return rdata=0 with err=1; writes pulse err one cycle after grant.
- Granted read sets rd_pending and captures rd_port and rd_err; next cycle the port rd_port gets rvalid=1 with rdata=mem_rdata (or 0 if rd_err).
- Writes produce no rvalid.
- Back-to-back grants are allowed every cycle, including a read on one port followed by an access on the other; return routing uses the captured rd_port, never the current grant.

## Timing
- Grant: same cycle as req (combinational from req and last_grant).
- Read latency: rvalid exactly 1 cycle after gnt; no backpressure on returns.
- Write: memory updated at the edge ending the grant cycle.
- Throughput: 1 access per cycle total; with both ports requesting continuously, each port gets every other cycle.
- Reset: last_grant=1 (port 0 wins the first tie), rd_pending=0, all rvalid/err=0, rdata=0. The memory outputs follow the combinational grant and are 0 while reset is high. All grants are suppressed during reset.
- Reset asserted with a read pending: the pending read is dropped; no rvalid after reset.
- A requester dropping req without gnt is legal; no state change.

## Structure
- Shared package dmem_pkg: DATA_WIDTH, strobe width 4, port index constants PORT_CPU=0 and PORT_DBG=1.
- Optional sub-module rr_arb2 holds the 2-way round-robin pick and the last_grant register. Routing, range check and the return path stay in dmem_arbiter.

## Test plan
- P0-only read of addr 0x10 with memory word 4 = 0xDEADBEEF -> p0_gnt same cycle; p0_rvalid next cycle with rdata 0xDEADBEEF; p1 outputs stay 0.
- Both request continuously for 6 cycles straight out of reset -> grants in order P0,P1,P0,P1,P0,P1.
- P1 write 0x12345678 with wstrb 4'b0011 to 0x20 over existing 0xAAAAAAAA, then P0 reads 0x20 -> P0 reads 0xAAAA5678.
- P0 read in cycle N, P1 read in cycle N+1 -> p0_rvalid at N+1 and p1_rvalid at N+2, each carrying its own word.
- P1 read at 0x400 with size 1024 -> gnt=1, mem_en=0; next cycle p1_rvalid=1, rdata=0, p1_err=1.
- Reset asserted the cycle after a P0 read grant -> no p0_rvalid. After release, a simultaneous request goes to P0 first.
